// File: rtl/seq_div_param.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor -> N-bit quotient and remainder.
// A zero divisor or a quotient too wide for N bits is flagged at acceptance and is not iterated.
module seq_div_param #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [2*N-1:0] word1,
    input  logic [N-1:0]   word2,
    output logic [N-1:0]   quotient,
    output logic [N-1:0]   remainder,
    output logic           ready,
    output logic           done,
    output logic           div_by_zero,
    output logic           overflow
);

    // state | meaning
    // IDLE  | waiting for start; holds the last result and flags
    // CALC  | one restoring iteration per clock, count tracks remaining steps
    typedef enum logic {IDLE, CALC} state_t;

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_t         state;
    logic [CW-1:0]  count;
    logic [2*N-1:0] dividend;
    logic [N-1:0]   divisor;
    logic [N:0]     diff;
    logic           lt;
    logic [2*N-1:0] dividend_next;

    assign diff = dividend[2*N-1:N-1] - {1'b0, divisor};
    assign lt   = diff[N];
    assign dividend_next = lt ? {dividend[2*N-2:0], 1'b0}
                              : {diff[N-1:0], dividend[N-2:0], 1'b1};

    assign quotient  = dividend[N-1:0];
    assign remainder = dividend[2*N-1:N];
    assign ready     = (state == IDLE) && reset;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            count       <= '0;
            dividend    <= '0;
            divisor     <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        divisor <= word2;
                        // Error results reuse the working register: all-ones quotient, high word as remainder.
                        if (word2 == '0) begin
                            div_by_zero <= 1'b1;
                            overflow    <= 1'b0;
                            dividend    <= {word1[2*N-1:N], {N{1'b1}}};
                            done        <= 1'b1;
                        end else if (word1[2*N-1:N] >= word2) begin
                            div_by_zero <= 1'b0;
                            overflow    <= 1'b1;
                            dividend    <= {word1[2*N-1:N], {N{1'b1}}};
                            done        <= 1'b1;
                        end else begin
                            div_by_zero <= 1'b0;
                            overflow    <= 1'b0;
                            dividend    <= word1;
                            count       <= CW'(N - 1);
                            state       <= CALC;
                        end
                    end
                end
                CALC: begin
                    dividend <= dividend_next;
                    if (count == '0) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div_param.sv
// Scoreboard bench for seq_div_param at N=4 and N=8: stimulus pushes expected results,
// per-instance monitors pop and compare whenever done pulses.
module tb_seq_div_param;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start4, start8;
    logic [7:0] w1_4;
    logic [3:0] w2_4;
    logic [15:0] w1_8;
    logic [7:0] w2_8;
    logic [3:0] q4, r4;
    logic [7:0] q8, r8;
    logic       ready4, done4, dz4, ov4;
    logic       ready8, done8, dz8, ov8;

    int n_vec = 0;
    int n_miss = 0;
    int cyc = 0;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        logic       ov;
        int         cyc;
    } exp_t;

    exp_t sb4[$];
    exp_t sb8[$];
    exp_t e4, e8;

    seq_div_param #(.N(4)) dut4 (
        .clk(clk), .reset(rst_n), .start(start4), .word1(w1_4), .word2(w2_4),
        .quotient(q4), .remainder(r4), .ready(ready4), .done(done4),
        .div_by_zero(dz4), .overflow(ov4)
    );

    seq_div_param #(.N(8)) dut8 (
        .clk(clk), .reset(rst_n), .start(start8), .word1(w1_8), .word2(w2_8),
        .quotient(q8), .remainder(r8), .ready(ready8), .done(done8),
        .div_by_zero(dz8), .overflow(ov8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (done4 === 1'b1) begin
            n_vec++;
            if (sb4.size() == 0) begin
                n_miss++;
                $display("FAIL done4_unexpected: q=%0h r=%0h at cycle %0d, nothing expected", q4, r4, cyc);
            end else begin
                e4 = sb4.pop_front();
                if ({q4, r4, dz4, ov4} !== {e4.q[3:0], e4.r[3:0], e4.dz, e4.ov} || cyc != e4.cyc) begin
                    n_miss++;
                    $display("FAIL result4: got q=%0h r=%0h dz=%0b ov=%0b cyc=%0d expected q=%0h r=%0h dz=%0b ov=%0b cyc=%0d",
                             q4, r4, dz4, ov4, cyc, e4.q[3:0], e4.r[3:0], e4.dz, e4.ov, e4.cyc);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            n_vec++;
            if (sb8.size() == 0) begin
                n_miss++;
                $display("FAIL done8_unexpected: q=%0h r=%0h at cycle %0d, nothing expected", q8, r8, cyc);
            end else begin
                e8 = sb8.pop_front();
                if ({q8, r8, dz8, ov8} !== {e8.q, e8.r, e8.dz, e8.ov} || cyc != e8.cyc) begin
                    n_miss++;
                    $display("FAIL result8: got q=%0h r=%0h dz=%0b ov=%0b cyc=%0d expected q=%0h r=%0h dz=%0b ov=%0b cyc=%0d",
                             q8, r8, dz8, ov8, cyc, e8.q, e8.r, e8.dz, e8.ov, e8.cyc);
                end
            end
        end
    end

    function automatic exp_t mk(input logic [7:0] q, input logic [7:0] r,
                                input logic dz, input logic ov, input int c);
        exp_t e;
        e.q = q; e.r = r; e.dz = dz; e.ov = ov; e.cyc = c;
        return e;
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge where done is expected.
    task automatic run4(input logic [7:0] w1, input logic [3:0] w2, input logic [3:0] eq,
                        input logic [3:0] er, input logic dz, input logic ov, input int lat);
        start4 = 1'b1; w1_4 = w1; w2_4 = w2;
        sb4.push_back(mk({4'h0, eq}, {4'h0, er}, dz, ov, cyc + 1 + lat));
        @(negedge clk);
        start4 = 1'b0;
        for (int i = 0; i < lat; i++) begin
            chk("ready4_busy", 32'(ready4), 32'd0);
            @(negedge clk);
        end
        chk("ready4_done", 32'(ready4), 32'd1);
    endtask

    task automatic run8(input logic [15:0] w1, input logic [7:0] w2, input logic [7:0] eq,
                        input logic [7:0] er, input logic dz, input logic ov, input int lat);
        start8 = 1'b1; w1_8 = w1; w2_8 = w2;
        sb8.push_back(mk(eq, er, dz, ov, cyc + 1 + lat));
        @(negedge clk);
        start8 = 1'b0;
        for (int i = 0; i < lat; i++) begin
            chk("ready8_busy", 32'(ready8), 32'd0);
            @(negedge clk);
        end
        chk("ready8_done", 32'(ready8), 32'd1);
    endtask

    initial begin
        // start asserted during reset must be ignored
        rst_n = 1'b0;
        start4 = 1'b1; w1_4 = 8'd100; w2_4 = 4'd7;
        start8 = 1'b1; w1_8 = 16'd50000; w2_8 = 8'd201;
        repeat (3) @(negedge clk);
        chk("rst_ready4", 32'(ready4), 32'd0);
        chk("rst_done4", 32'(done4), 32'd0);
        chk("rst_q4", 32'(q4), 32'd0);
        chk("rst_r4", 32'(r4), 32'd0);
        chk("rst_flags4", 32'({dz4, ov4}), 32'd0);
        chk("rst_ready8", 32'(ready8), 32'd0);
        start4 = 1'b0; start8 = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("rel_ready4", 32'(ready4), 32'd1);
        @(negedge clk);
        chk("rel_done4", 32'(done4), 32'd0);
        chk("rel_q4", 32'(q4), 32'd0);

        run4(8'd100, 4'd7, 4'd14, 4'd2, 1'b0, 1'b0, 4);
        run4(8'hF0, 4'd3, 4'hF, 4'hF, 1'b0, 1'b1, 0);
        run4(8'h25, 4'd0, 4'hF, 4'h2, 1'b1, 1'b0, 0);
        run4(8'h70, 4'd7, 4'hF, 4'h7, 1'b0, 1'b1, 0);
        run4(8'h6F, 4'd7, 4'd15, 4'd6, 1'b0, 1'b0, 4);
        run4(8'h00, 4'd1, 4'd0, 4'd0, 1'b0, 1'b0, 4);
        @(negedge clk);
        chk("hold_q4", 32'(q4), 32'd0);
        chk("hold_ready4", 32'(ready4), 32'd1);

        // start pulse while busy, with operands changing mid-operation
        start4 = 1'b1; w1_4 = 8'd100; w2_4 = 4'd7;
        sb4.push_back(mk(8'd14, 8'd2, 1'b0, 1'b0, cyc + 5));
        @(negedge clk);
        start4 = 1'b0; w1_4 = 8'h3C; w2_4 = 4'd5;
        @(negedge clk);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        repeat (2) @(negedge clk);
        chk("busy_done_ready4", 32'(ready4), 32'd1);
        repeat (3) @(negedge clk);

        // start held high: second operation loaded in the done cycle
        start4 = 1'b1; w1_4 = 8'd100; w2_4 = 4'd7;
        sb4.push_back(mk(8'd14, 8'd2, 1'b0, 1'b0, cyc + 5));
        repeat (5) @(negedge clk);
        chk("b2b_done4", 32'(done4), 32'd1);
        w1_4 = 8'h3C; w2_4 = 4'd5;
        sb4.push_back(mk(8'd12, 8'd0, 1'b0, 1'b0, cyc + 5));
        @(negedge clk);
        chk("b2b_busy4", 32'(ready4), 32'd0);
        repeat (4) @(negedge clk);
        start4 = 1'b0;
        chk("b2b_done4_2", 32'(done4), 32'd1);
        @(negedge clk);

        // reset during CALC aborts without done
        start4 = 1'b1; w1_4 = 8'd100; w2_4 = 4'd7;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_q4", 32'(q4), 32'd0);
        chk("abort_r4", 32'(r4), 32'd0);
        chk("abort_ready4", 32'(ready4), 32'd0);
        chk("abort_done4", 32'(done4), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_rel_ready4", 32'(ready4), 32'd1);
        repeat (8) @(negedge clk);
        chk("abort_idle_q4", 32'(q4), 32'd0);

        run4(8'h3C, 4'd5, 4'd12, 4'd0, 1'b0, 1'b0, 4);

        run8(16'd50000, 8'd201, 8'd248, 8'd152, 1'b0, 1'b0, 8);
        run8(16'hFEFF, 8'hFF, 8'hFF, 8'hFE, 1'b0, 1'b0, 8);
        run8(16'hFFFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b1, 0);
        run8(16'h1234, 8'h00, 8'hFF, 8'h12, 1'b1, 1'b0, 0);

        repeat (20) @(negedge clk);
        chk("sb4_drained", 32'(sb4.size()), 32'd0);
        chk("sb8_drained", 32'(sb8.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
